// File: rtl/id_pkg.sv
// id_pkg -- shared decode definitions for the instruction-decode stage.
//   Opcode constants, ALU-op encodings, instruction field positions,
//   the EX control bundle and a pure opcode decoder.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;  // address calc
  localparam logic [1:0] ALUOP_SUB  = 2'b01;  // compare
  localparam logic [1:0] ALUOP_FUNC = 2'b10;  // funct field decides

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  // Controls carried into EX
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // Full decode: EX controls plus ID-local hazard/steering hints
  typedef struct packed {
    ctrl_t ctrl;
    logic  regdst;   // destination is rd (else rt)
    logic  is_beq;
    logic  uses_rt;  // rt is a source operand
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.aluop    = ALUOP_FUNC;
        d.regdst        = 1'b1;
        d.uses_rt       = 1'b1;
      end
      OP_LW: begin
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memread  = 1'b1;
        d.ctrl.memtoreg = 1'b1;
        d.ctrl.regwrite = 1'b1;
        d.ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memwrite = 1'b1;
        d.ctrl.aluop    = ALUOP_ADD;
        d.uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.aluop    = ALUOP_SUB;
        d.is_beq        = 1'b1;
        d.uses_rt       = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile -- register file with same-cycle writeback bypass.
//   clk, rst     : clock, async active-low reset (clears all registers)
//   we/waddr/wdata : writeback port; writes to register 0 are dropped
//   ra1/ra2      : read addresses
//   rd1/rd2      : read data; register 0 reads zero, a read that matches
//                  an active write returns the write data this cycle
module id_regfile #(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [REG_DIR_WIDTH-1:0] waddr,
  input  logic [REG_WIDTH-1:0]     wdata,
  input  logic [REG_DIR_WIDTH-1:0] ra1,
  input  logic [REG_DIR_WIDTH-1:0] ra2,
  output logic [REG_WIDTH-1:0]     rd1,
  output logic [REG_WIDTH-1:0]     rd2
);

  logic [REG_FILE_DEPTH-1:0][REG_WIDTH-1:0] regs;

  // Entry 0 is only ever reset, so it stays hard zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < REG_FILE_DEPTH; i++) begin
        if (we && waddr == REG_DIR_WIDTH'(i)) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0)                 rd1 = '0;
    else if (we && waddr == ra1)   rd1 = wdata;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0)                 rd2 = '0;
    else if (we && waddr == ra2)   rd2 = wdata;
  end

endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage -- instruction decode stage with ID/EX register.
//   clk, rst          : clock, async active-low reset
//   if_valid/if_instr/if_pcnext : fetched instruction and its PC+1
//   wb_we/wb_addr/wb_data       : writeback into the register file
//   stall             : IF must hold its instruction (load-use / branch)
//   br_taken/br_target: beq resolved here, redirect to IF (combinational)
//   ex_*              : registered ID/EX payload and controls
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3,
  parameter int PC_WIDTH       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [PC_WIDTH-1:0]      if_pcnext,
  input  logic                     wb_we,
  input  logic [REG_DIR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]     wb_data,
  output logic                     stall,
  output logic                     br_taken,
  output logic [PC_WIDTH-1:0]      br_target,
  output logic                     ex_valid,
  output logic [REG_WIDTH-1:0]     ex_rd1,
  output logic [REG_WIDTH-1:0]     ex_rd2,
  output logic [REG_WIDTH-1:0]     ex_imm,
  output logic [REG_DIR_WIDTH-1:0] ex_dst,
  output logic                     ex_alusrc,
  output logic                     ex_memtoreg,
  output logic                     ex_memwrite,
  output logic                     ex_memread,
  output logic                     ex_regwrite,
  output logic [1:0]               ex_aluop
);

  localparam int STAGES = 2;  // [1] = ID/EX, [2] = MEM shadow

  logic [5:0]               op;
  logic [REG_DIR_WIDTH-1:0] rs, rt, rd;
  logic [15:0]              imm16;
  logic [31:0]              imm_sx;
  dec_t                     dec;
  logic [REG_WIDTH-1:0]     rd1, rd2;

  logic [STAGES:1]          vld_pipe;
  ctrl_t                    ex_ctrl;
  logic [REG_DIR_WIDTH-1:0] mem_dst;
  logic                     mem_regwrite, mem_memread;
  logic                     kill;

  logic id_vld, load_use, ex_pend, mem_pend, br_hazard, stall_i, issue, eq;
  logic unused_bits;

  assign op     = if_instr[OP_LSB +: 6];
  assign rs     = if_instr[RS_LSB +: REG_DIR_WIDTH];
  assign rt     = if_instr[RT_LSB +: REG_DIR_WIDTH];
  assign rd     = if_instr[RD_LSB +: REG_DIR_WIDTH];
  assign imm16  = if_instr[15:0];
  assign imm_sx = {{16{imm16[15]}}, imm16};
  assign dec    = decode(op);

  // Field bits beyond the configured address widths are don't-care.
  assign unused_bits = ^{if_instr, imm_sx};

  id_regfile #(
    .REG_WIDTH      (REG_WIDTH),
    .REG_FILE_DEPTH (REG_FILE_DEPTH),
    .REG_DIR_WIDTH  (REG_DIR_WIDTH)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // The slot after a taken branch is the wrong-path fetch.
  assign id_vld = if_valid & ~kill;

  // Loaded data is not available until after MEM: one bubble.
  assign load_use = vld_pipe[1] & ex_ctrl.memread & (ex_dst != '0) &
                    ((ex_dst == rs) | (dec.uses_rt & (ex_dst == rt)));

  // beq compares in ID, so it must wait for any producer still in EX or MEM.
  assign ex_pend  = ex_ctrl.regwrite & (ex_dst != '0) &
                    ((ex_dst == rs) | (ex_dst == rt));
  assign mem_pend = vld_pipe[2] & (mem_regwrite | mem_memread) & (mem_dst != '0) &
                    ((mem_dst == rs) | (mem_dst == rt));
  assign br_hazard = dec.is_beq & (ex_pend | mem_pend);

  assign stall_i = id_vld & (load_use | br_hazard);
  assign issue   = id_vld & ~stall_i;
  assign eq      = (rd1 == rd2);

  assign stall     = rst & stall_i;
  assign br_taken  = rst & issue & dec.is_beq & eq;
  // Low PC_WIDTH bits of the sign-extended offset give the wrapped sum.
  assign br_target = if_pcnext + imm16[PC_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe     <= '0;
      ex_ctrl      <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_dst       <= '0;
      mem_dst      <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      kill         <= 1'b0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], issue};
      mem_dst      <= ex_dst;
      mem_regwrite <= ex_ctrl.regwrite;
      mem_memread  <= ex_ctrl.memread;
      kill         <= br_taken;
      if (issue) begin
        ex_ctrl <= dec.ctrl;
        ex_rd1  <= rd1;
        ex_rd2  <= rd2;
        ex_imm  <= imm_sx[REG_WIDTH-1:0];
        // Non-writers carry no destination so they never look like producers.
        ex_dst  <= dec.ctrl.regwrite ? (dec.regdst ? rd : rt) : '0;
      end else begin
        ex_ctrl <= '0;
        ex_rd1  <= '0;
        ex_rd2  <= '0;
        ex_imm  <= '0;
        ex_dst  <= '0;
      end
    end
  end

  assign ex_valid    = vld_pipe[1];
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule
